// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: register scoreboard for multicycle (load/mul/div) writes.
// Tracks per-register pending writes and the outstanding long-op count,
// raises decode stalls on RAW/WAW/capacity hazards, and runs a drain
// handshake (RUN -> DRAIN -> ACK) for fence/ecall.
module scoreboard_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        uses_rs1,
  input  logic        uses_rs2,
  input  logic        reg_write,
  input  logic        long_op,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        drain_req,
  output logic        issue,
  output logic        stall,
  output logic [31:0] busy_mask,
  output logic [3:0]  inflight,
  output logic        drain_ack,
  output logic        wb_err
);

  typedef enum logic [1:0] {RUN, DRAIN, ACK} state_e;

  localparam logic [3:0] CAP = 4'(MAX_INFLIGHT);

  state_e      state_q, state_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  inflight_q, inflight_d;
  logic        wb_err_q, wb_err_d;

  logic [31:0] clr_mask, eff_busy, set_mask, clr_eff;
  logic        haz, cap_full, go, inc, dec, wb_bad;

  // Writeback clear mask; a writeback is visible to decode in the same cycle.
  always_comb begin
    clr_mask = '0;
    if (wb_valid) clr_mask[wb_rd] = 1'b1;
    eff_busy = busy_q & ~clr_mask;
  end

  // Hazard detection: RAW on either source, WAW on rd, long-op capacity.
  always_comb begin
    cap_full = (inflight_q == CAP);
    haz = (uses_rs1 & eff_busy[rs1])
        | (uses_rs2 & eff_busy[rs2])
        | (reg_write & eff_busy[rd])
        | (long_op & reg_write & (rd != 5'd0) & cap_full & ~wb_valid);
  end

  // FSM outputs: reset forces a transparent, non-stalling decode.
  always_comb begin
    go        = instr_valid & ~flush;
    stall     = 1'b0;
    issue     = go;
    drain_ack = 1'b0;
    if (!rst) begin
      stall     = go & (haz | (state_q != RUN));
      issue     = go & ~(haz | (state_q != RUN));
      drain_ack = (state_q == ACK);
    end
  end

  // Scoreboard next state; only genuinely pending writebacks retire a slot,
  // a bogus one flags wb_err and leaves the count and mask alone.
  always_comb begin
    inc      = issue & long_op & reg_write & (rd != 5'd0);
    dec      = wb_valid & busy_q[wb_rd] & (inflight_q != 4'd0);
    wb_bad   = wb_valid & (~busy_q[wb_rd] | (inflight_q == 4'd0));
    set_mask = '0;
    if (inc) set_mask[rd] = 1'b1;
    clr_eff  = dec ? clr_mask : '0;
    // Set is applied after clear so a same-cycle set of the same register wins.
    busy_d     = (busy_q & ~clr_eff) | set_mask;
    busy_d[0]  = 1'b0;
    inflight_d = inflight_q + 4'(inc) - 4'(dec);
    wb_err_d   = wb_err_q | wb_bad;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (inflight_d == 4'd0) state_d = ACK;
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register and scoreboard registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      busy_q     <= '0;
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_mask = busy_q;
  assign inflight  = inflight_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed testbench for scoreboard_ctrl: expected values are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        uses_rs1, uses_rs2, reg_write, long_op, flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        drain_req;
  logic        issue, stall, drain_ack, wb_err;
  logic [31:0] busy_mask;
  logic [3:0]  inflight;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   ntests = 0;
  int   nfail  = 0;

  scoreboard_ctrl #(.MAX_INFLIGHT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .uses_rs1   (uses_rs1),
    .uses_rs2   (uses_rs2),
    .reg_write  (reg_write),
    .long_op    (long_op),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .drain_req  (drain_req),
    .issue      (issue),
    .stall      (stall),
    .busy_mask  (busy_mask),
    .inflight   (inflight),
    .drain_ack  (drain_ack),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; reg_write = 1'b0; long_op = 1'b0;
    flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; drain_req = 1'b0;
  endtask

  task automatic instr(input logic [4:0] d, input logic lo,
                       input logic [4:0] s1, input logic u1);
    instr_valid = 1'b1; rd = d; reg_write = 1'b1; long_op = lo;
    rs1 = s1; uses_rs1 = u1;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
  endtask

  task automatic want(input string tag, input logic [31:0] v);
    exp_t it;
    it.tag = tag;
    it.val = v;
    exp_q.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t it;
    ntests++;
    if (exp_q.size() == 0) begin
      nfail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      it = exp_q.pop_front();
      assert (obs === it.val) else begin
        nfail++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.val);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: decode is transparent, all state cleared.
    idle(); rst = 1'b1; instr_valid = 1'b1;
    cyc(); cyc();
    want("rst_issue", 32'd1); want("rst_stall", 32'd0); want("rst_ack", 32'd0);
    want("rst_busy", 32'd0);  want("rst_infl", 32'd0);  want("rst_err", 32'd0);
    chk(32'(issue)); chk(32'(stall)); chk(32'(drain_ack));
    chk(busy_mask); chk(32'(inflight)); chk(32'(wb_err));
    rst = 1'b0; idle(); cyc();

    // Load-use on x5.
    instr(5'd5, 1'b1, 5'd0, 1'b0);
    want("lu_issue", 32'd1); #1 chk(32'(issue));
    want("lu_busy", 32'h20); want("lu_infl", 32'd1);
    cyc(); chk(busy_mask); chk(32'(inflight));
    idle(); instr(5'd6, 1'b0, 5'd5, 1'b1);
    want("lu_stall", 32'd1); want("lu_noissue", 32'd0);
    #1 chk(32'(stall)); chk(32'(issue));
    cyc();
    wb(5'd5);
    want("lu_wb_issue", 32'd1); #1 chk(32'(issue));
    want("lu_busy_clr", 32'd0); want("lu_infl_clr", 32'd0);
    cyc(); chk(busy_mask); chk(32'(inflight));
    idle();

    // Capacity: four outstanding, fifth stalls until a writeback frees a slot.
    for (int i = 1; i <= 4; i++) begin
      idle(); instr(5'(i), 1'b1, 5'd0, 1'b0); cyc();
    end
    idle();
    want("cap_infl", 32'd4); want("cap_busy", 32'h1E);
    #1 chk(32'(inflight)); chk(busy_mask);
    instr(5'd6, 1'b1, 5'd0, 1'b0);
    want("cap_stall", 32'd1); #1 chk(32'(stall));
    wb(5'd1);
    want("cap_wb_issue", 32'd1); #1 chk(32'(issue));
    want("cap_infl_hold", 32'd4); want("cap_busy2", 32'h5C);
    cyc(); chk(32'(inflight)); chk(busy_mask);
    idle();
    wb(5'd2); cyc(); wb(5'd3); cyc(); wb(5'd4); cyc(); wb(5'd6); cyc();
    idle();
    want("cap_empty_infl", 32'd0); want("cap_empty_busy", 32'd0); want("cap_err", 32'd0);
    #1 chk(32'(inflight)); chk(busy_mask); chk(32'(wb_err));

    // x0 is never tracked.
    instr(5'd0, 1'b1, 5'd0, 1'b0);
    want("x0_issue", 32'd1); #1 chk(32'(issue));
    want("x0_busy", 32'd0); want("x0_infl", 32'd0);
    cyc(); chk(busy_mask); chk(32'(inflight));
    idle();

    // WAW: single-cycle write to x7 waits for the long op to x7.
    instr(5'd7, 1'b1, 5'd0, 1'b0); cyc(); idle();
    instr(5'd7, 1'b0, 5'd0, 1'b0);
    want("waw_stall", 32'd1); #1 chk(32'(stall));
    cyc();
    want("waw_stall2", 32'd1); #1 chk(32'(stall));
    flush = 1'b1;
    want("fl_issue", 32'd0); want("fl_stall", 32'd0); want("fl_busy", 32'h80);
    #1 chk(32'(issue)); chk(32'(stall)); chk(busy_mask);
    cyc();
    want("fl_infl", 32'd1); #1 chk(32'(inflight));
    flush = 1'b0;
    wb(5'd7);
    want("waw_wb_issue", 32'd1); #1 chk(32'(issue));
    want("waw_busy", 32'd0); want("waw_infl", 32'd0);
    cyc(); chk(busy_mask); chk(32'(inflight));
    idle();

    // Same-register set and clear in one cycle: set wins, count unchanged.
    instr(5'd8, 1'b1, 5'd0, 1'b0); cyc(); idle();
    instr(5'd8, 1'b1, 5'd0, 1'b0); wb(5'd8);
    want("sc_issue", 32'd1); #1 chk(32'(issue));
    want("sc_busy", 32'h100); want("sc_infl", 32'd1);
    cyc(); chk(busy_mask); chk(32'(inflight));
    idle(); wb(5'd8); cyc(); idle();
    want("sc_infl0", 32'd0); #1 chk(32'(inflight));

    // Drain with two outstanding ops.
    instr(5'd10, 1'b1, 5'd0, 1'b0); cyc(); idle();
    instr(5'd11, 1'b1, 5'd0, 1'b0); cyc(); idle();
    want("dr_infl2", 32'd2); #1 chk(32'(inflight));
    drain_req = 1'b1; cyc();
    instr(5'd12, 1'b0, 5'd0, 1'b0);
    want("dr_issue", 32'd0); want("dr_stall", 32'd1); want("dr_ack0", 32'd0);
    #1 chk(32'(issue)); chk(32'(stall)); chk(32'(drain_ack));
    wb(5'd10);
    want("dr_wb_issue", 32'd0); #1 chk(32'(issue));
    want("dr_infl1", 32'd1); want("dr_ack_early", 32'd0);
    cyc(); chk(32'(inflight)); chk(32'(drain_ack));
    wb(5'd11); cyc();
    drain_req = 1'b0; wb_valid = 1'b0;
    want("dr_ack", 32'd1); want("dr_infl0", 32'd0); want("dr_ack_stall", 32'd1);
    #1 chk(32'(drain_ack)); chk(32'(inflight)); chk(32'(stall));
    cyc();
    want("dr_ack_pulse", 32'd0); want("dr_run_issue", 32'd1);
    #1 chk(32'(drain_ack)); chk(32'(issue));
    idle();

    // Drain with nothing outstanding: ack two cycles after the request.
    drain_req = 1'b1; cyc(); drain_req = 1'b0;
    want("dz_ack0", 32'd0); #1 chk(32'(drain_ack));
    cyc();
    want("dz_ack1", 32'd1); #1 chk(32'(drain_ack));
    cyc();
    want("dz_ack_end", 32'd0); #1 chk(32'(drain_ack));

    // Writeback to a non-busy register sets the sticky error.
    wb(5'd9);
    want("err_set", 32'd1); want("err_infl", 32'd0); want("err_busy", 32'd0);
    cyc(); chk(32'(wb_err)); chk(32'(inflight)); chk(busy_mask);
    idle(); cyc(); cyc();
    want("err_sticky", 32'd1); #1 chk(32'(wb_err));

    // Reset in the middle of a drain with three ops in flight.
    for (int i = 1; i <= 3; i++) begin
      idle(); instr(5'(i), 1'b1, 5'd0, 1'b0); cyc();
    end
    idle(); drain_req = 1'b1; cyc(); drain_req = 1'b0;
    want("rd_infl3", 32'd3); #1 chk(32'(inflight));
    instr(5'd13, 1'b0, 5'd1, 1'b1);
    want("rd_stall", 32'd1); #1 chk(32'(stall));
    rst = 1'b1;
    want("rd_rst_stall", 32'd0); want("rd_rst_issue", 32'd1); want("rd_rst_ack", 32'd0);
    #1 chk(32'(stall)); chk(32'(issue)); chk(32'(drain_ack));
    cyc();
    want("rd_busy", 32'd0); want("rd_infl", 32'd0); want("rd_err", 32'd0); want("rd_ack", 32'd0);
    chk(busy_mask); chk(32'(inflight)); chk(32'(wb_err)); chk(32'(drain_ack));
    rst = 1'b0;
    want("rd_post_issue", 32'd1); #1 chk(32'(issue));
    cyc(); idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
